pp_reduce_pipe: RTL and testbench

- Pipelined reduction stage directly downstream of the radix-4 Booth partial-product generator.
- Consumes the eight 32-bit partial products PP0..PP7 and reduces them through two 4:2 carry-save levels and a final carry-propagate adder.
- Produces the 32-bit product, i.e. the sum of all PPs mod 2^32.
- Uses a valid/ready handshake with per-stage stall and bubble collapsing, so it can sit between a producer and a consumer that is not always ready.

---
 rtl/pp_reduce_pipe_if.sv | 32 +++
 rtl/pp_reduce_pipe.sv | 136 +++++++++++++
 tb/tb_pp_reduce_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_reduce_pipe_if.sv
// Handshake bundle for pp_reduce_pipe: PP-set input side and product output side.
// slave is the reduction pipe's view; master is the producer/consumer side.
interface pp_reduce_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] pp0;
   logic [WIDTH-1:0] pp1;
   logic [WIDTH-1:0] pp2;
   logic [WIDTH-1:0] pp3;
   logic [WIDTH-1:0] pp4;
   logic [WIDTH-1:0] pp5;
   logic [WIDTH-1:0] pp6;
   logic [WIDTH-1:0] pp7;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] product;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, in_tag, out_ready,
      output in_ready, out_valid, product, out_tag
   );

   modport master (
      output in_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, in_tag, out_ready,
      input  in_ready, out_valid, product, out_tag
   );
endinterface

// File: rtl/pp_reduce_pipe.sv
// Booth partial-product reduction: two 4:2 CSA levels plus CPA, valid/ready pipelined.
// Define PP_REDUCE_FAST_EN to drop the CPA register stage (latency 2, capacity 2).
module pp_reduce_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input logic             clk,
   input logic             rst_n,
   pp_reduce_pipe_if.slave bus
);
   typedef logic [WIDTH-1:0] word_t;
   typedef logic [TAG_W-1:0] tag_t;

   typedef struct packed {
      word_t s;
      word_t c;
   } csa_t;

   // Two chained 3:2 layers; carries above bit WIDTH-1 fall off at each shift.
   function automatic csa_t csa42(input word_t a, input word_t b, input word_t c, input word_t d);
      word_t s1;
      word_t c1;
      csa_t  r;
      s1  = a ^ b ^ c;
      c1  = ((a & b) | (a & c) | (b & c)) << 1;
      r.s = s1 ^ d ^ c1;
      r.c = ((s1 & d) | (s1 & c1) | (d & c1)) << 1;
      return r;
   endfunction

   // Stage S1 state
   logic  v1;
   word_t s_a;
   word_t c_a;
   word_t s_b;
   word_t c_b;
   tag_t  tag1;

   // Stage S2 state
   logic  v2;
   word_t s_r;
   word_t c_r;
   tag_t  tag2;

   logic  adv1;
   logic  adv2;
   logic  accept;
   csa_t  lvl1_a;
   csa_t  lvl1_b;
   csa_t  lvl2;

   always_comb begin
      lvl1_a = csa42(bus.pp0, bus.pp1, bus.pp2, bus.pp3);
      lvl1_b = csa42(bus.pp4, bus.pp5, bus.pp6, bus.pp7);
      lvl2   = csa42(s_a, c_a, s_b, c_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         s_a  <= '0;
         c_a  <= '0;
         s_b  <= '0;
         c_b  <= '0;
         tag1 <= '0;
      end else if (adv1) begin
         v1 <= accept;
         if (accept) begin
            s_a  <= lvl1_a.s;
            c_a  <= lvl1_a.c;
            s_b  <= lvl1_b.s;
            c_b  <= lvl1_b.c;
            tag1 <= bus.in_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2   <= 1'b0;
         s_r  <= '0;
         c_r  <= '0;
         tag2 <= '0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            s_r  <= lvl2.s;
            c_r  <= lvl2.c;
            tag2 <= tag1;
         end
      end
   end

`ifdef PP_REDUCE_FAST_EN
   always_comb begin
      adv2          = ~v2 | bus.out_ready;
      adv1          = ~v1 | adv2;
      accept        = bus.in_valid & adv1;
      bus.in_ready  = adv1;
      bus.out_valid = v2;
      bus.product   = s_r + c_r;
      bus.out_tag   = tag2;
   end
`else
   // Stage S3 state
   logic  v3;
   word_t prod_r;
   tag_t  tag3;
   logic  adv3;

   always_comb begin
      adv3          = ~v3 | bus.out_ready;
      adv2          = ~v2 | adv3;
      adv1          = ~v1 | adv2;
      accept        = bus.in_valid & adv1;
      bus.in_ready  = adv1;
      bus.out_valid = v3;
      bus.product   = prod_r;
      bus.out_tag   = tag3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3     <= 1'b0;
         prod_r <= '0;
         tag3   <= '0;
      end else if (adv3) begin
         v3 <= v2;
         if (v2) begin
            prod_r <= s_r + c_r;
            tag3   <= tag2;
         end
      end
   end
`endif
endmodule

// File: tb/tb_pp_reduce_pipe.sv
// Self-checking bench for pp_reduce_pipe: vector table, stall/order/reset sequences, random traffic.
// Honours PP_REDUCE_FAST_EN for the expected latency and capacity.
module tb_pp_reduce_pipe;
   typedef logic [31:0] pp_arr_t [8];

   typedef struct {
      pp_arr_t     pp;
      logic [3:0]  tag;
      logic [31:0] expv;
   } vec_t;

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] prod;
   } sb_t;

`ifdef PP_REDUCE_FAST_EN
   localparam int LAT = 2;
   localparam int CAP = 2;
`else
   localparam int LAT = 3;
   localparam int CAP = 3;
`endif

   logic clk;
   logic rst_n;

   pp_reduce_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();

   pp_reduce_pipe #(.WIDTH(32), .TAG_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total;
   int          bad;
   int          n_out;
   int          run_len;
   int          max_run;
   logic [31:0] exp_next;
   sb_t         sb [$];
   vec_t        tbl [7];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, expv);
      end
   endfunction

   function automatic logic [31:0] sum8(input pp_arr_t p);
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) s = s + p[i];
      return s;
   endfunction

   task automatic set_pp(input pp_arr_t p);
      bus.pp0 = p[0]; bus.pp1 = p[1]; bus.pp2 = p[2]; bus.pp3 = p[3];
      bus.pp4 = p[4]; bus.pp5 = p[5]; bus.pp6 = p[6]; bus.pp7 = p[7];
   endtask

   // Called at posedge+1; returns at posedge+1 after the op was accepted.
   task automatic send(input pp_arr_t p, input logic [3:0] t, input logic [31:0] e);
      int w;
      set_pp(p);
      bus.in_tag   = t;
      exp_next     = e;
      bus.in_valid = 1'b1;
      w = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         w++;
         if (w > 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles want acceptance", w);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int w;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      repeat (2) @(posedge clk);
      #1;
      check(name, sb.size(), 0);
   endtask

   // Monitor: scoreboard push on accept, pop/compare on transfer, hold check while stalled.
   initial begin
      logic        stalled;
      logic [31:0] held_p;
      logic [3:0]  held_t;
      sb_t         e;
      stalled = 1'b0;
      held_p  = '0;
      held_t  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
            run_len = 0;
         end else begin
            if (stalled) begin
               check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
               check("hold_product", bus.product, held_p);
               check("hold_tag", {28'd0, bus.out_tag}, {28'd0, held_t});
            end
            if (bus.out_valid && bus.out_ready) begin
               n_out++;
               run_len++;
               if (run_len > max_run) max_run = run_len;
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_output: got tag %h product %h want no output", bus.out_tag, bus.product);
               end else begin
                  e = sb.pop_front();
                  check("sb_tag", {28'd0, bus.out_tag}, {28'd0, e.tag});
                  check("sb_product", bus.product, e.prod);
               end
            end else begin
               run_len = 0;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held_p  = bus.product;
            held_t  = bus.out_tag;
            if (bus.in_valid && bus.in_ready) sb.push_back('{bus.in_tag, exp_next});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      pp_arr_t     p;
      int          k;
      int          lat;
      int          w;
      int          base_out;
      logic [31:0] held;
      bit          prod_done;

      total = 0; bad = 0; n_out = 0; run_len = 0; max_run = 0; exp_next = '0;
      tbl[0] = '{'{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, 4'd5, 32'd36};
      tbl[1] = '{'{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'd1, 32'hFFFF_FFF8};
      tbl[2] = '{'{32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 4'd2, 32'h0};
      tbl[3] = '{'{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 4'd3, 32'h8000_0000};
      tbl[4] = '{'{32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA,
                   32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555}, 4'd4, 32'hFFFF_FFFC};
      tbl[5] = '{'{32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000,
                   32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000}, 4'hF, 32'h8000_0000};
      tbl[6] = '{'{32'h1, 32'h10, 32'h100, 32'h1000, 32'h1_0000, 32'h10_0000, 32'h100_0000, 32'h1000_0000},
                 4'd6, 32'h1111_1111};

      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_tag = '0;
      for (int i = 0; i < 8; i++) p[i] = '0;
      set_pp(p);

      // Reset state
      #12;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_product", bus.product, 32'd0);
      check("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      #11 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency from acceptance to out_valid
      bus.out_ready = 1'b1;
      set_pp(tbl[0].pp);
      bus.in_tag = tbl[0].tag;
      exp_next = tbl[0].expv;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("lat_accept", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid) break;
      end
      check("latency", lat, LAT);
      check("lat_product", bus.product, 32'd36);
      check("lat_tag", {28'd0, bus.out_tag}, 32'd5);
      @(posedge clk);
      #1;
      drain("drain_latency");

      // Vector table, back-to-back
      foreach (tbl[i]) send(tbl[i].pp, tbl[i].tag, tbl[i].expv);
      drain("drain_table");

      // Fill with consumer stalled, then release
      bus.out_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < 8; i++) p[i] = 32'(k * 8 + i + 1) * 32'h0101_0101;
         set_pp(p);
         bus.in_tag = 4'(k);
         exp_next = sum8(p);
         bus.in_valid = (k < 4);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) k++;
         @(posedge clk);
         #1;
      end
      check("full_accepted", k, CAP);
      check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
      held = bus.product;
      repeat (3) @(posedge clk);
      #1;
      check("full_product_stable", bus.product, held);
      max_run = 0;
      bus.out_ready = 1'b1;
      w = 0;
      while (k < 4 && w < 20) begin
         for (int i = 0; i < 8; i++) p[i] = 32'(k * 8 + i + 1) * 32'h0101_0101;
         set_pp(p);
         bus.in_tag = 4'(k);
         exp_next = sum8(p);
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (bus.in_ready) k++;
         @(posedge clk);
         #1;
         w++;
      end
      drain("drain_full");
      check("full_release_run", max_run, 4);

      // Ten-op stream at full rate
      max_run = 0;
      for (int n = 0; n < 10; n++) begin
         for (int i = 0; i < 8; i++) p[i] = $urandom;
         send(p, 4'(n + 7), sum8(p));
      end
      drain("drain_stream");
      check("stream_run", max_run, 10);

      // Asynchronous reset with two ops in flight
      bus.out_ready = 1'b0;
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < 8; i++) p[i] = $urandom;
         send(p, 4'(n + 9), sum8(p));
      end
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      check("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("arst_product", bus.product, 32'd0);
      check("arst_out_tag", {28'd0, bus.out_tag}, 32'd0);
      sb.delete();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      base_out = n_out;
      repeat (10) @(negedge clk);
      check("reset_no_ghost", n_out - base_out, 0);
      @(posedge clk);
      #1;

      // Random valid/ready traffic
      base_out = n_out;
      prod_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               int gap;
               gap = $urandom_range(0, 2);
               if (gap != 0) begin
                  bus.in_valid = 1'b0;
                  repeat (gap) begin
                     @(posedge clk);
                     #1;
                  end
               end
               for (int i = 0; i < 8; i++) p[i] = $urandom;
               send(p, 4'(n), sum8(p));
            end
            bus.in_valid = 1'b0;
            prod_done = 1'b1;
         end
         begin
            while (!prod_done) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      drain("drain_random");
      check("random_count", n_out - base_out, 1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
